// File: rtl/sr_event_reader.sv
// sr_event_reader
//   Read-side companion of the CPU status register. Each cycle the SR bus is
//   compared with its previous value. Selected rising/falling transitions are
//   collected into sticky pending bits that drive an interrupt request. A
//   consumer takes an atomic, clear-on-read snapshot over a valid/ack handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   SRData     live status register contents
//   rd_req     snapshot request (level, sampled only while idle)
//   rd_ack     snapshot consumed (sampled only while presenting)
//   rd_valid   snapshot outputs valid and held stable
//   rd_events  captured pending event bits
//   rd_sr      SRData value at capture
//   rd_ovr     captured overrun flag (an event hit an already pending bit)
//   irq        high while any pending bit is set
//   rd_count   captured event count (optional, see below)
//
// Optional feature
//   `define SR_EVT_COUNT_EN builds a saturating 8-bit event counter. Each
//   snapshot returns its value in rd_count and clears it. Without the macro,
//   rd_count is tied to zero.

module sr_event_reader #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RISE_MASK = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] FALL_MASK = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SRData,
  input  logic             rd_req,
  input  logic             rd_ack,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_events,
  output logic [WIDTH-1:0] rd_sr,
  output logic             rd_ovr,
  output logic             irq,
  output logic [7:0]       rd_count
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sr_q;
  logic             primed_q;
  logic [WIDTH-1:0] pending;
  logic             ovr_q;

  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] next_pending;
  logic             capture;
  logic             evt_hit;

  // Until the first edge after reset has loaded sr_q, the previous value is
  // meaningless. Suppress events so the reset value cannot look like a rise.
  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    evt = '0;
    if (primed_q) begin
      evt = (SRData & ~sr_q & RISE_MASK) | (~SRData & sr_q & FALL_MASK);
    end
  end

  assign capture = (state == ST_IDLE) && rd_req;
  assign evt_hit = |(evt & pending);

  // The snapshot takes pending|evt on the capture edge. An event arriving on
  // that same edge goes into the snapshot and never into the cleared register.
  assign next_pending = capture ? '0 : (pending | evt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sr_q      <= '0;
      primed_q  <= 1'b0;
      pending   <= '0;
      ovr_q     <= 1'b0;
      irq       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_events <= '0;
      rd_sr     <= '0;
      rd_ovr    <= 1'b0;
    end else begin
      sr_q     <= SRData;
      primed_q <= 1'b1;
      pending  <= next_pending;
      irq      <= |next_pending;

      if (capture) begin
        rd_events <= pending | evt;
        rd_sr     <= SRData;
        rd_ovr    <= ovr_q | evt_hit;
        ovr_q     <= 1'b0;
        rd_valid  <= 1'b1;
        state     <= ST_PRESENT;
      end else begin
        ovr_q <= ovr_q | evt_hit;
        if ((state == ST_PRESENT) && rd_ack) begin
          rd_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      end
    end
  end

`ifdef SR_EVT_COUNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = PW + 9;

  logic [7:0]    count_q;
  logic [PW-1:0] evt_pop;
  logic [SW-1:0] cnt_sum;
  logic [7:0]    cnt_sat;

  always_comb begin
    evt_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      evt_pop = evt_pop + PW'(evt[i]);
    end
  end

  // Saturate the running total including this edge's events. The snapshot
  // therefore also covers events that coincide with capture.
  assign cnt_sum = SW'(count_q) + SW'(evt_pop);
  assign cnt_sat = (cnt_sum > SW'(255)) ? 8'hFF : cnt_sum[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= 8'h00;
      rd_count <= 8'h00;
    end else if (capture) begin
      rd_count <= cnt_sat;
      count_q  <= 8'h00;
    end else begin
      count_q  <= cnt_sat;
    end
  end
`else
  assign rd_count = 8'h00;
`endif

endmodule

// File: tb/tb_sr_event_reader.sv
// tb_sr_event_reader
//   Self-checking bench for sr_event_reader. Two instances share clock, reset
//   and the SR bus. u0 uses the default masks (all rises). u1 detects only
//   falls of bit 0. A bit-level behavioural model predicts every output, and
//   a negedge process compares all outputs against it each cycle. Directed
//   phases add hand-computed literal expectations.

module tb_sr_event_reader;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       sr_data = 8'hFF;
  logic [1:0]       req = 2'b00;
  logic [1:0]       ack = 2'b00;
  logic [1:0]       valid_o;
  logic [1:0]       ovr_o;
  logic [1:0]       irq_o;
  logic [1:0][7:0]  ev_o;
  logic [1:0][7:0]  sro_o;
  logic [1:0][7:0]  cnt_o;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  sr_event_reader #(.WIDTH(8), .RISE_MASK(8'hFF), .FALL_MASK(8'h00)) u0 (
    .clk(clk), .rst(rst), .SRData(sr_data), .rd_req(req[0]), .rd_ack(ack[0]),
    .rd_valid(valid_o[0]), .rd_events(ev_o[0]), .rd_sr(sro_o[0]),
    .rd_ovr(ovr_o[0]), .irq(irq_o[0]), .rd_count(cnt_o[0])
  );

  sr_event_reader #(.WIDTH(8), .RISE_MASK(8'h00), .FALL_MASK(8'h01)) u1 (
    .clk(clk), .rst(rst), .SRData(sr_data), .rd_req(req[1]), .rd_ack(ack[1]),
    .rd_valid(valid_o[1]), .rd_events(ev_o[1]), .rd_sr(sro_o[1]),
    .rd_ovr(ovr_o[1]), .irq(irq_o[1]), .rd_count(cnt_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_prev [2];
  logic [7:0] m_pend [2];
  logic [7:0] m_ev_s [2];
  logic [7:0] m_sr_s [2];
  logic       m_primed [2];
  logic       m_ovr [2];
  logic       m_ovr_s [2];
  logic       m_busy [2];
  logic       m_irq [2];
  int         m_cnt [2];
  int         m_cnt_s [2];

  function automatic bit rise_en(input int i, input int b);
    logic [7:0] m;
    m = (i == 0) ? 8'hFF : 8'h00;
    return m[b];
  endfunction

  function automatic bit fall_en(input int i, input int b);
    logic [7:0] m;
    m = (i == 0) ? 8'h00 : 8'h01;
    return m[b];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_prev[i] = 8'h00; m_pend[i] = 8'h00; m_ev_s[i] = 8'h00; m_sr_s[i] = 8'h00;
        m_primed[i] = 1'b0; m_ovr[i] = 1'b0; m_ovr_s[i] = 1'b0; m_busy[i] = 1'b0;
        m_irq[i] = 1'b0; m_cnt[i] = 0; m_cnt_s[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] ev;
        int         n_ev;
        bit         hit;
        int         total;
        ev = 8'h00; n_ev = 0; hit = 1'b0;
        if (m_primed[i]) begin
          for (int b = 0; b < 8; b++) begin
            if ((!m_prev[i][b] && sr_data[b] && rise_en(i, b)) ||
                (m_prev[i][b] && !sr_data[b] && fall_en(i, b))) begin
              ev[b] = 1'b1;
              n_ev++;
              if (m_pend[i][b]) hit = 1'b1;
            end
          end
        end
        total = m_cnt[i] + n_ev;
        if (total > 255) total = 255;
        if (!m_busy[i] && req[i]) begin
          m_ev_s[i]  = m_pend[i] | ev;
          m_sr_s[i]  = sr_data;
          m_ovr_s[i] = m_ovr[i] | hit;
          m_cnt_s[i] = total;
          m_pend[i]  = 8'h00;
          m_ovr[i]   = 1'b0;
          m_cnt[i]   = 0;
          m_busy[i]  = 1'b1;
        end else begin
          m_pend[i] = m_pend[i] | ev;
          m_ovr[i]  = m_ovr[i] | hit;
          m_cnt[i]  = total;
          if (m_busy[i] && ack[i]) m_busy[i] = 1'b0;
        end
        m_irq[i]    = (m_pend[i] != 8'h00);
        m_prev[i]   = sr_data;
        m_primed[i] = 1'b1;
      end
    end
  end

  function automatic logic [7:0] exp_count(input int i);
`ifdef SR_EVT_COUNT_EN
    return 8'(m_cnt_s[i]);
`else
    return 8'h00;
`endif
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d rd_valid", i),  32'(valid_o[i]), 32'(m_busy[i]));
        check($sformatf("u%0d rd_events", i), 32'(ev_o[i]),    32'(m_ev_s[i]));
        check($sformatf("u%0d rd_sr", i),     32'(sro_o[i]),   32'(m_sr_s[i]));
        check($sformatf("u%0d rd_ovr", i),    32'(ovr_o[i]),   32'(m_ovr_s[i]));
        check($sformatf("u%0d irq", i),       32'(irq_o[i]),   32'(m_irq[i]));
        check($sformatf("u%0d rd_count", i),  32'(cnt_o[i]),   32'(exp_count(i)));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sr(input logic [7:0] v);
    sr_data = v;
    cyc();
  endtask

  task automatic take(input int i);
    int k;
    k = 0;
    req[i] = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!valid_o[i] && k < 8);
    check($sformatf("u%0d take rd_valid", i), 32'(valid_o[i]), 32'd1);
    req[i] = 1'b0;
  endtask

  task automatic release_rd(input int i);
    ack[i] = 1'b1;
    cyc();
    check($sformatf("u%0d release rd_valid", i), 32'(valid_o[i]), 32'd0);
    ack[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;

    // Reset priming: held in reset with SR all ones, then released.
    cyc(2);
    cmp_en = 1'b1;
    cyc();
    check("reset rd_valid", 32'(valid_o[0]), 32'd0);
    check("reset rd_events", 32'(ev_o[0]), 32'h00);
    check("reset rd_sr", 32'(sro_o[0]), 32'h00);
    check("reset irq", 32'(irq_o), 32'h0);
    rst = 1'b1;
    cyc(4);
    check("prime irq u0", 32'(irq_o[0]), 32'd0);
    check("prime irq u1", 32'(irq_o[1]), 32'd0);

    // Falls are not events under the default masks.
    set_sr(8'h01);
    check("fall ignored u0", 32'(irq_o[0]), 32'd0);
    check("steady bit u1", 32'(irq_o[1]), 32'd0);

    // Fall mask (u1): 01 -> 00 is an event, 00 -> 01 is not.
    set_sr(8'h00);
    check("fall irq u1", 32'(irq_o[1]), 32'd1);
    check("fall no irq u0", 32'(irq_o[0]), 32'd0);
    take(1);
    check("fall rd_events u1", 32'(ev_o[1]), 32'h01);
    check("fall rd_sr u1", 32'(sro_o[1]), 32'h00);
    release_rd(1);
    set_sr(8'h01);
    check("rise ignored u1", 32'(irq_o[1]), 32'd0);
    check("rise irq u0", 32'(irq_o[0]), 32'd1);
    take(0);
    check("flush rd_events u0", 32'(ev_o[0]), 32'h01);
    release_rd(0);

    // Rise detect with a multi-bit pattern.
    set_sr(8'h00);
    set_sr(8'h25);
    check("rise irq 1 edge", 32'(irq_o[0]), 32'd1);
    take(0);
    check("rise rd_events", 32'(ev_o[0]), 32'h25);
    check("rise rd_sr", 32'(sro_o[0]), 32'h25);
    check("rise rd_ovr", 32'(ovr_o[0]), 32'd0);
    check("rise irq after capture", 32'(irq_o[0]), 32'd0);
    release_rd(0);
    check("rise irq after ack", 32'(irq_o[0]), 32'd0);

    // Overrun: bit0 toggled 0->1->0->1 before reading.
    set_sr(8'h24);
    set_sr(8'h25);
    set_sr(8'h24);
    set_sr(8'h25);
    take(0);
    check("ovr rd_events", 32'(ev_o[0]), 32'h01);
    check("ovr rd_ovr", 32'(ovr_o[0]), 32'd1);
    // Snapshot held while a new event accumulates during PRESENT.
    set_sr(8'h00);
    set_sr(8'h80);
    check("hold rd_events", 32'(ev_o[0]), 32'h01);
    check("hold rd_sr", 32'(sro_o[0]), 32'h25);
    check("hold irq", 32'(irq_o[0]), 32'd1);
    release_rd(0);
    check("pending kept irq", 32'(irq_o[0]), 32'd1);
    take(0);
    check("next rd_events", 32'(ev_o[0]), 32'h80);
    check("next rd_ovr", 32'(ovr_o[0]), 32'd0);
    release_rd(0);

    // Event coincident with the capture edge.
    set_sr(8'h00);
    sr_data = 8'h2A;
    take(0);
    check("coinc rd_events", 32'(ev_o[0]), 32'h2A);
    check("coinc irq", 32'(irq_o[0]), 32'd0);
    release_rd(0);
    check("coinc irq after ack", 32'(irq_o[0]), 32'd0);

    // Back-to-back: req and ack held high give one snapshot every 2 cycles.
    highs = 0;
    req[0] = 1'b1;
    ack[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sr_data = 8'h10 + 8'(k);
      cyc();
      if (valid_o[0]) highs++;
    end
    req[0] = 1'b0;
    ack[0] = 1'b0;
    check("b2b snapshot count", 32'(highs), 32'd4);
    check("b2b ends idle", 32'(valid_o[0]), 32'd0);

    // Empty capture, then event counting.
    set_sr(8'h00);
    take(0);
    release_rd(0);
    take(0);
    check("empty rd_events", 32'(ev_o[0]), 32'h00);
    check("empty rd_ovr", 32'(ovr_o[0]), 32'd0);
    check("empty rd_count", 32'(cnt_o[0]), 32'd0);
    release_rd(0);
    set_sr(8'hFF);
    set_sr(8'h00);
    set_sr(8'hFF);
    take(0);
    check("count rd_events", 32'(ev_o[0]), 32'hFF);
    check("count rd_ovr", 32'(ovr_o[0]), 32'd1);
`ifdef SR_EVT_COUNT_EN
    check("count 16", 32'(cnt_o[0]), 32'd16);
`else
    check("count tied 0", 32'(cnt_o[0]), 32'd0);
`endif
    release_rd(0);
    for (int k = 0; k < 40; k++) begin
      set_sr(8'h00);
      set_sr(8'hFF);
    end
    take(0);
`ifdef SR_EVT_COUNT_EN
    check("count saturated", 32'(cnt_o[0]), 32'd255);
`else
    check("count tied 0 sat", 32'(cnt_o[0]), 32'd0);
`endif
    release_rd(0);

    // Reset in the middle of a handshake aborts the snapshot.
    set_sr(8'h00);
    set_sr(8'h0F);
    take(0);
    check("pre-reset rd_events", 32'(ev_o[0]), 32'h0F);
    #2 rst = 1'b0;
    #1;
    check("async reset rd_valid", 32'(valid_o[0]), 32'd0);
    check("async reset irq", 32'(irq_o[0]), 32'd0);
    check("async reset rd_events", 32'(ev_o[0]), 32'h00);
    cyc();
    rst = 1'b1;
    cyc(3);
    check("re-prime irq u0", 32'(irq_o[0]), 32'd0);
    check("re-prime rd_valid", 32'(valid_o[0]), 32'd0);

    cyc();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sr_event_reader.md
Name: sr_event_reader

Overview:
- Read-side companion of the CPU status register (SR).
- Watches the SR output bus every cycle and detects rising and falling transitions on selected flag bits.
- Accumulates detected transitions into sticky pending bits, raises an interrupt request, and lets a consumer take an atomic snapshot with clear-on-read over a valid/ack handshake.
- Sits between SR and the interrupt/debug logic.

Parameters:
- WIDTH, 8, width of the SR data bus and of the pending register.
- RISE_MASK, 8'hFF, bit i set: a 0->1 transition on SRData[i] is an event.
- FALL_MASK, 8'h00, bit i set: a 1->0 transition on SRData[i] is an event.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- SRData  in  WIDTH  live status register contents.
- rd_req  in  1  consumer requests a snapshot; level, sampled only in IDLE.
- rd_ack  in  1  consumer has taken the snapshot; sampled only in PRESENT.
- rd_valid  out  1  snapshot outputs are valid and held stable.
- rd_events  out  WIDTH  captured pending event bits.
- rd_sr  out  WIDTH  SRData value at capture.
- rd_ovr  out  1  captured overrun flag.
- irq  out  1  high while any pending bit is set (OR of pending).
- rd_count  out  8  captured event count (optional feature only).

Behaviour:
- Reset (rst=0, async) clears the following to 0:
  - sr_q, primed_q, pending, ovr_q;
  - rd_valid, rd_events, rd_sr, rd_ovr, irq, rd_count;
  - FSM state goes to IDLE.
- Every edge: sr_q <= SRData; primed_q <= 1.
- Event detection:
  - evt = primed_q ? ((SRData & ~sr_q & RISE_MASK) | (~SRData & sr_q & FALL_MASK)) : 0.
  - The first edge after reset loads sr_q without generating events, so there are no spurious rises from the reset value.
- Latency: SRData changes before edge k; the pending bit is set and irq is high after edge k (1 cycle).
- Overrun: any evt bit whose pending bit is already 1 sets ovr_q (sticky) on that edge.
- FSM IDLE:
  - rd_req=0: pending <= pending | evt.
  - rd_req=1 at edge: rd_events <= pending | evt; rd_sr <= SRData; rd_ovr <= ovr_q | (evt & pending != 0).
  - Same edge: pending <= 0; ovr_q <= 0; rd_valid <= 1; go to PRESENT.
  - An event coincident with capture lands in the snapshot, never lost and never duplicated.
- FSM PRESENT:
  - rd_events, rd_sr and rd_ovr are held stable; pending keeps accumulating; rd_req is ignored.
  - rd_ack=1 at edge: rd_valid <= 0; go to IDLE.
  - rd_ack in IDLE has no effect.
- Back-to-back reads: rd_req held high through rd_ack gives one IDLE cycle, then the next capture. Minimum spacing is 2 cycles per snapshot.
- Empty capture: rd_req with pending=0 still completes the handshake with rd_events=0.
- irq is registered (irq <= |next_pending) and drops on the edge of the capture that clears pending.
- Reset mid-handshake aborts the snapshot: rd_valid=0, pending is lost, primed_q=0.

Optional Feature:
- Macro: SR_EVT_COUNT_EN.
- Defined:
  - An 8-bit counter adds popcount(evt) each edge and saturates at 255.
  - On capture, rd_count <= saturated(count + popcount(evt)) and count <= 0. The capture-edge total is saturated at 255 before loading.
  - During PRESENT, counting restarts from 0.
- Not defined: no counter is built; rd_count is tied to 8'h00.

Test Plan:
- Reset priming: rst=0 with SRData=8'hFF, release rst, hold 8'hFF for 4 cycles -> pending=0, irq=0 (no spurious rise).
- Rise detect (defaults): SRData 8'h00 -> 8'h25 -> irq=1 after 1 edge; rd_req -> rd_valid=1, rd_events=8'h25, rd_sr=8'h25; rd_ack -> rd_valid=0; irq=0.
- Fall mask: FALL_MASK=8'h01, RISE_MASK=8'h00; SRData 8'h01 -> 8'h00 -> rd_events=8'h01; SRData 8'h00 -> 8'h01 -> no event.
- Overrun and hold:
  - Toggle bit0 0->1->0->1 before a read -> rd_events[0]=1, rd_ovr=1.
  - While in PRESENT, SRData 8'h00 -> 8'h80 -> rd_events unchanged; pending[7]=1; the next read returns 8'h80 with rd_ovr=0.
- Coincident capture: SRData 8'h00 -> 8'h2A on the same edge rd_req is sampled -> rd_events=8'h2A; after ack, pending=0 and irq=0.
- Count (SR_EVT_COUNT_EN): SRData sequence 8'h00, 8'hFF, 8'h00, 8'hFF -> rd_count=16. With 40 such 8-bit rises before a read -> rd_count=255 (saturated).
